// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin arbiter that shares the single write port of a
//               synchronous FIFO among REQ_NUM requesters. Each grant is a
//               burst of up to BURST_LEN words from one requester, throttled
//               by the FIFO full flag.
// Ports       : clk               - rising-edge clock
//               rst_n             - asynchronous active-low reset
//               req_i             - per-requester "word available" flags
//               req_data_i        - packed words, requester i at [i*WIDTH +: WIDTH]
//               accept_o          - one-hot, word of requester i consumed this cycle
//               grant_o           - one-hot registered port owner, zero when idle
//               fifo_full_i       - FIFO full flag
//               fifo_write_req_o  - FIFO write strobe
//               fifo_write_data_o - FIFO write data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int REQ_NUM   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_NUM-1:0]       req_i,
    input  logic [REQ_NUM*WIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]       accept_o,
    output logic [REQ_NUM-1:0]       grant_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_write_req_o,
    output logic [WIDTH-1:0]         fifo_write_data_o
);

    localparam int                IDX_W      = $clog2(REQ_NUM);
    localparam int                CNT_W      = $clog2(BURST_LEN) + 1;
    localparam logic [IDX_W-1:0]  C_PTR_RST  = IDX_W'(REQ_NUM - 1);
    localparam logic [IDX_W:0]    C_REQ_NUM  = (IDX_W + 1)'(REQ_NUM);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [REQ_NUM-1:0] C_ONE     = {{(REQ_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [REQ_NUM-1:0]  grant_q;

    logic [IDX_W-1:0]    pick_d;
    logic                pick_found;
    logic [IDX_W:0]      cand;
    logic                owner_req;
    logic                acc_any;
    logic                burst_end;

    // Round-robin search: examine ptr+1, ptr+2, ... wrapping modulo REQ_NUM.
    // The first hit wins, so the requester just served is considered last.
    always_comb begin
        pick_d     = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= C_REQ_NUM) begin
                cand = cand - C_REQ_NUM;
            end
            if (!pick_found && req_i[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_d     = cand[IDX_W-1:0];
            end
        end
    end

    // A word moves only while bursting, the owner has data and the FIFO has room.
    assign owner_req = req_i[owner_q];
    assign acc_any   = (state_q == ST_BURST) && owner_req && !fifo_full_i;
    // Dropping req ends the burst even during a full stall.
    assign burst_end = !owner_req || (acc_any && (cnt_q == C_CNT_LAST));

    always_comb begin
        accept_o          = '0;
        fifo_write_data_o = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (owner_q == IDX_W'(i)) begin
                accept_o[i] = acc_any;
                if (state_q == ST_BURST) begin
                    fifo_write_data_o = req_data_i[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign fifo_write_req_o = acc_any;
    assign grant_o          = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= C_PTR_RST;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        owner_q <= pick_d;
                        grant_q <= C_ONE << pick_d;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (burst_end) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= owner_q;
                        cnt_q   <= '0;
                    end else if (acc_any) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter. A transaction-level
//               model predicts grant/accept/write outputs every cycle for two
//               instances (BURST_LEN=4 and BURST_LEN=1); directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance 0: BURST_LEN = 4, fed from per-requester word queues
    logic [3:0]  req0 = '0;
    logic [31:0] data0 = '0;
    logic        full0 = 1'b0;
    logic [3:0]  acc0, gnt0;
    logic        wr0;
    logic [7:0]  wd0;

    // Instance 1: BURST_LEN = 1, driven directly
    logic [3:0]  req1 = '0;
    logic [31:0] data1 = '0;
    logic        full1 = 1'b0;
    logic [3:0]  acc1, gnt1;
    logic        wr1;
    logic [7:0]  wd1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.REQ_NUM(4), .WIDTH(8), .BURST_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .req_data_i(data0),
        .accept_o(acc0), .grant_o(gnt0), .fifo_full_i(full0),
        .fifo_write_req_o(wr0), .fifo_write_data_o(wd0)
    );

    fifo_write_arbiter #(.REQ_NUM(4), .WIDTH(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req1), .req_data_i(data1),
        .accept_o(acc1), .grant_o(gnt1), .fifo_full_i(full1),
        .fifo_write_req_o(wr1), .fifo_write_data_o(wd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- stimulus word queues for instance 0 ----------------
    logic [7:0] words [4][16];
    int         head [4];
    int         tail [4];
    logic [3:0] en = '0;
    logic       full_ctl = 1'b0;
    logic [3:0] acc0_s = '0;

    task automatic push(input int r, input logic [7:0] w);
        words[r][tail[r]] = w;
        tail[r]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en = '0;
    endtask

    // Consume words accepted in the previous cycle, then present the next ones.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc0_s[i] && head[i] < tail[i]) head[i]++;
            req0[i] = en[i] && (head[i] < tail[i]);
            data0[i*8 +: 8] = req0[i] ? words[i][head[i]] : 8'h00;
        end
        full0 = full_ctl;
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit busy;
        int owner;
        int last;   // requester served most recently
        int left;   // words still allowed in the current burst
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.busy = 0; m.owner = 0; m.last = 3; m.left = 0;
        return m;
    endfunction

    function automatic void mdl_eval(input mdl_t m, input int bl, input logic [3:0] req,
                                     input logic [31:0] data, input logic full,
                                     output logic [3:0] g, output logic [3:0] a,
                                     output logic w, output logic [7:0] d, output mdl_t n);
        bit found;
        n = m;
        g = '0; a = '0; w = 1'b0; d = '0;
        if (m.busy) begin
            g = 4'(1 << m.owner);
            d = data[m.owner*8 +: 8];
            if (req[m.owner] && !full) begin
                a = g;
                w = 1'b1;
            end
            if (!req[m.owner]) begin
                n.busy = 0;
                n.last = m.owner;
            end else if (w) begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.busy = 0;
                    n.last = m.owner;
                end
            end
        end else if (req != 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req[(m.last + k) % 4]) begin
                    found   = 1;
                    n.owner = (m.last + k) % 4;
                end
            end
            n.busy = 1;
            n.left = bl;
        end
    endfunction

    mdl_t m0, m1, n0, m1n;

    initial begin
        m0 = mdl_reset();
        m1 = mdl_reset();
        n0 = m0;
        m1n = m1;
    end

    // Compare both instances against the model in the middle of every cycle.
    always @(negedge clk) begin
        logic [3:0] eg, ea;
        logic       ew;
        logic [7:0] ed;
        if (!rst_n) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end
        mdl_eval(m0, 4, req0, data0, full0, eg, ea, ew, ed, n0);
        chk("m0_grant", {28'h0, gnt0}, {28'h0, eg});
        chk("m0_accept", {28'h0, acc0}, {28'h0, ea});
        chk("m0_wreq", {31'h0, wr0}, {31'h0, ew});
        chk("m0_wdata", {24'h0, wd0}, {24'h0, ed});
        mdl_eval(m1, 1, req1, data1, full1, eg, ea, ew, ed, m1n);
        chk("m1_grant", {28'h0, gnt1}, {28'h0, eg});
        chk("m1_accept", {28'h0, acc1}, {28'h0, ea});
        chk("m1_wreq", {31'h0, wr1}, {31'h0, ew});
        chk("m1_wdata", {24'h0, wd1}, {24'h0, ed});
        acc0_s = acc0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m0 = n0;
            m1 = m1n;
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_queues();
        full_ctl = 1'b0;
        req1 = '0;
        data1 = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int seen;
        clear_queues();

        // Reset state
        do_reset();
        chk("rst_grant", {28'h0, gnt0}, 32'h0);
        chk("rst_wreq", {31'h0, wr0}, 32'h0);

        // 1: single requester, six words
        for (int k = 0; k < 6; k++) push(0, 8'(8'h10 + k));
        en[0] = 1'b1;
        @(negedge clk); chk("t1_c0_grant", {28'h0, gnt0}, 32'h0);
        @(negedge clk); chk("t1_c1_grant", {28'h0, gnt0}, 32'h1);
        chk("t1_c1_wdata", {24'h0, wd0}, 32'h10);
        chk("t1_c1_wreq", {31'h0, wr0}, 32'h1);
        repeat (3) @(negedge clk);
        chk("t1_c4_wdata", {24'h0, wd0}, 32'h13);
        @(negedge clk); chk("t1_c5_grant", {28'h0, gnt0}, 32'h0);
        chk("t1_c5_wreq", {31'h0, wr0}, 32'h0);
        chk("t1_c5_wdata", {24'h0, wd0}, 32'h0);
        @(negedge clk); chk("t1_c6_grant", {28'h0, gnt0}, 32'h1);
        chk("t1_c6_wdata", {24'h0, wd0}, 32'h14);
        @(negedge clk); chk("t1_c7_wdata", {24'h0, wd0}, 32'h15);
        repeat (4) @(posedge clk);

        // 2: all four requesting continuously
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) push(r, 8'(r * 16 + k));
        en = 4'b1111;
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            chk("t2_grant_order", {28'h0, gnt0}, 32'(1 << (b % 4)));
            repeat (4) @(negedge clk);
        end
        @(posedge clk);
        en = '0;
        repeat (3) @(posedge clk);

        // 3: full stall after requester 2's second word
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 8'(8'h20 + k));
        en[2] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk);
            if (acc0[2]) seen++;
        end
        chk("t3_two_words", seen, 2);
        @(posedge clk);
        full_ctl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(0, 8'(8'h50 + k));
            push(3, 8'(8'h60 + k));
        end
        en = 4'b1101;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_wreq", {31'h0, wr0}, 32'h0);
            chk("t3_stall_grant", {28'h0, gnt0}, 32'h4);
            chk("t3_stall_accept", {28'h0, acc0}, 32'h0);
            @(posedge clk);
        end
        full_ctl = 1'b0;
        @(negedge clk); chk("t3_word3", {24'h0, wd0}, 32'h22);
        chk("t3_word3_acc", {28'h0, acc0}, 32'h4);
        @(negedge clk); chk("t3_word4", {24'h0, wd0}, 32'h23);
        repeat (12) @(posedge clk);

        // 4: requester 1 drops after two words
        do_reset();
        push(1, 8'h30); push(1, 8'h31);
        en[1] = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("t4_c1_grant", {28'h0, gnt0}, 32'h2);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            push(0, 8'(8'h70 + k)); push(2, 8'(8'h80 + k)); push(3, 8'(8'h90 + k));
        end
        en = 4'b1111;
        @(negedge clk);
        @(negedge clk); chk("t4_drop_grant", {28'h0, gnt0}, 32'h2);
        chk("t4_drop_acc", {28'h0, acc0}, 32'h0);
        @(negedge clk); chk("t4_idle_grant", {28'h0, gnt0}, 32'h0);
        @(negedge clk); chk("t4_next_grant", {28'h0, gnt0}, 32'h4);
        repeat (6) @(posedge clk);

        // 5: reset mid-burst
        do_reset();
        for (int k = 0; k < 4; k++) push(0, 8'(8'hA0 + k));
        en[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (acc0[0]) seen = 1;
        end
        chk("t5_first_write", seen, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_grant", {28'h0, gnt0}, 32'h0);
        chk("t5_async_acc", {28'h0, acc0}, 32'h0);
        chk("t5_async_wreq", {31'h0, wr0}, 32'h0);
        chk("t5_async_wdata", {24'h0, wd0}, 32'h0);
        clear_queues();
        for (int k = 0; k < 4; k++) push(3, 8'(8'hB0 + k));
        en[3] = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); chk("t5_idle_grant", {28'h0, gnt0}, 32'h0);
        @(negedge clk); chk("t5_grant3", {28'h0, gnt0}, 32'h8);
        chk("t5_wdata3", {24'h0, wd0}, 32'hB0);
        repeat (6) @(posedge clk);

        // 6: BURST_LEN=1 instance, requesters 0 and 2
        do_reset();
        #1;
        data1 = {8'h00, 8'hC2, 8'h00, 8'hA0};
        req1  = 4'b0101;
        @(negedge clk); chk("t6_c0_grant", {28'h0, gnt1}, 32'h0);
        @(negedge clk); chk("t6_c1_grant", {28'h0, gnt1}, 32'h1);
        chk("t6_c1_wdata", {24'h0, wd1}, 32'hA0);
        @(negedge clk); chk("t6_c2_grant", {28'h0, gnt1}, 32'h0);
        @(negedge clk); chk("t6_c3_grant", {28'h0, gnt1}, 32'h4);
        chk("t6_c3_wdata", {24'h0, wd1}, 32'hC2);
        @(negedge clk); chk("t6_c4_grant", {28'h0, gnt1}, 32'h0);
        @(negedge clk); chk("t6_c5_grant", {28'h0, gnt1}, 32'h1);
        @(posedge clk);
        #1 req1 = '0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
